// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with a
// single global advance enable driven by output backpressure.

module pbs_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shift_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shift_o,
  output logic             dir_o,
  output logic [1:0]       mode_o
);
  localparam int SH = 1 << K;

  logic [WIDTH-1:0] shl, shr, sar, rol, ror, data_d;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   shift_q;
  logic             valid_q, dir_q;
  logic [1:0]       mode_q;

  assign shl = data_i << SH;
  assign shr = data_i >> SH;
  // Earlier stages shift in the same direction, so the MSB here is still the operand sign.
  assign sar = $signed(data_i) >>> SH;
  assign rol = (data_i << SH) | (data_i >> (WIDTH - SH));
  assign ror = (data_i >> SH) | (data_i << (WIDTH - SH));

  always_comb begin
    data_d = data_i;
    if (shift_i[K]) begin
      if (!dir_i) begin
        data_d = (mode_i == 2'b00) ? rol : shl;
      end else begin
        case (mode_i)
          2'b00:   data_d = ror;
          2'b10:   data_d = sar;
          default: data_d = shr;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shift_q <= shift_i;
      dir_q   <= dir_i;
      mode_q  <= mode_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shift_o = shift_q;
  assign dir_o   = dir_q;
  assign mode_o  = mode_q;
endmodule

module pipe_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shift,
  input  logic             direction,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW:0]     inflight
);
  // Index 0 is the raw input; index k+1 is the register of stage k.
  logic [SHW:0]            vld_pipe;
  logic [SHW:0][WIDTH-1:0] data_p;
  logic [SHW:0][SHW-1:0]   shift_p;
  logic [SHW:0]            dir_p;
  logic [SHW:0][1:0]       mode_p;
  logic                    en;
  logic [SHW:0]            inflight_c;
  logic                    unused_tail;

  assign en       = !vld_pipe[SHW] | out_ready;
  assign in_ready = en;

  assign vld_pipe[0] = in_valid;
  assign data_p[0]   = in_data;
  assign shift_p[0]  = shift;
  assign dir_p[0]    = direction;
  assign mode_p[0]   = mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    pbs_stage #(.WIDTH(WIDTH), .SHW(SHW), .K(k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .valid_i (vld_pipe[k]),
      .data_i  (data_p[k]),
      .shift_i (shift_p[k]),
      .dir_i   (dir_p[k]),
      .mode_i  (mode_p[k]),
      .valid_o (vld_pipe[k+1]),
      .data_o  (data_p[k+1]),
      .shift_o (shift_p[k+1]),
      .dir_o   (dir_p[k+1]),
      .mode_o  (mode_p[k+1])
    );
  end

  // Control fields are fully consumed by the time the operand leaves the last stage.
  assign unused_tail = ^{shift_p[SHW], dir_p[SHW], mode_p[SHW]};

  always_comb begin
    inflight_c = '0;
    for (int k = 1; k <= SHW; k++) inflight_c = inflight_c + (SHW+1)'(vld_pipe[k]);
  end

  assign inflight  = inflight_c;
  assign out_valid = vld_pipe[SHW];
  assign out_data  = data_p[SHW];
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter (WIDTH = 8): directed steps plus a random
// stream, all results checked in order against a bit-level reference model.

module tb_pipe_barrel_shifter;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk, rst_n;
  logic             in_valid, in_ready, direction, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [SHW-1:0]   shift;
  logic [1:0]       mode;
  logic [SHW:0]     inflight;

  int checks = 0, passes = 0, fails = 0, npop = 0;
  logic [7:0] q[$];

  pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift(shift), .direction(direction), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic dr, input logic [1:0] m);
    logic [7:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (!dr) begin
        src = i - int'(s);
        if (src >= 0) r[i] = d[src];
        else          r[i] = (m == 2'b00) ? d[src+8] : 1'b0;
      end else begin
        src = i + int'(s);
        if (src < 8)  r[i] = d[src];
        else          r[i] = (m == 2'b00) ? d[src-8] : ((m == 2'b10) ? d[7] : 1'b0);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop/compare on retire, push on accept, occupancy must track inflight.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inflight_vs_sb", 32'(inflight), 32'(q.size()));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          chk("sb_data", 32'(out_data), 32'(q.pop_front()));
          npop++;
        end
      end
      if (in_valid && in_ready) q.push_back(ref_shift(in_data, shift, direction, mode));
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic dr, input logic [1:0] m);
    int t;
    in_valid = 1'b1; in_data = d; shift = s; direction = dr; mode = m;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 100);
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    chk("wait_out", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || inflight != 0) && t < 200) begin @(negedge clk); t++; end
    chk("drained", 32'(inflight), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, sent, cyc, base;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0;
    direction = 1'b0; mode = '0; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_inflight",  32'(inflight),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Rotate left with latency measurement
    send(8'h81, 3'd1, 1'b0, 2'b00);
    wait_out(n);
    chk("rotl_latency", 32'(n), 32'd3);
    chk("rotl_data", 32'(out_data), 32'h03);
    drain();

    // Arithmetic then logical right, back-to-back
    send(8'h90, 3'd3, 1'b1, 2'b10);
    send(8'h90, 3'd3, 1'b1, 2'b01);
    wait_out(n);
    chk("sar_data", 32'(out_data), 32'hF2);
    @(negedge clk);
    chk("shr_valid", 32'(out_valid), 32'd1);
    chk("shr_data", 32'(out_data), 32'h12);
    drain();

    // Backpressure: three fill the pipe, a fourth waits at the input
    out_ready = 1'b0;
    send(8'hA5, 3'd2, 1'b0, 2'b01);
    send(8'h3C, 3'd1, 1'b1, 2'b00);
    send(8'h80, 3'd2, 1'b1, 2'b10);
    in_valid = 1'b1; in_data = 8'h0F; shift = 3'd3; direction = 1'b0; mode = 2'b11;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_stable", 32'(out_data), 32'h94);
      chk("bp_inflight", 32'(inflight), 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_retire_inflight", 32'(inflight), 32'd3);
    drain();

    // Rotate right, then shift 0 in every mode/direction
    send(8'h81, 3'd4, 1'b1, 2'b00);
    wait_out(n);
    chk("rotr_data", 32'(out_data), 32'h18);
    for (int m = 0; m < 3; m++) begin
      send(8'h81, 3'd0, 1'b0, 2'(m));
      send(8'h81, 3'd0, 1'b1, 2'(m));
    end
    repeat (3) begin
      @(negedge clk);
      chk("sh0_valid", 32'(out_valid), 32'd1);
      chk("sh0_data", 32'(out_data), 32'h81);
    end
    drain();

    // Reset with two operands in flight
    send(8'h55, 3'd1, 1'b0, 2'b00);
    send(8'hAA, 3'd2, 1'b1, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_inflight", 32'(inflight), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random stream
    base = npop; sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      shift     = 3'($urandom);
      direction = 1'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_sent", 32'(sent), 32'd1000);
    drain();
    chk("rand_retired", 32'(npop - base), 32'd1000);
    chk("sb_empty_end", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipe_barrel_shifter.md
PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; power of two, >= 2.
REQ-002 SHALL have derived localparam SHW = log2(WIDTH), the shift-amount width and the pipeline depth.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, high when the input operand is presented.
REQ-006 SHALL have port in_ready, output, 1, high when the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, the operand.
REQ-008 SHALL have port shift, input, SHW, the shift amount, 0..WIDTH-1.
REQ-009 SHALL have port direction, input, 1: 0 = left, 1 = right.
REQ-010 SHALL have port mode, input, 2: 00 rotate, 01 logical, 10 arithmetic, 11 treated as logical.
REQ-011 SHALL have port out_valid, output, 1, high when out_data holds a result.
REQ-012 SHALL have port out_ready, input, 1, high when the consumer takes the result.
REQ-013 SHALL have port out_data, output, WIDTH, the shifted result.
REQ-014 SHALL have port inflight, output, SHW+1, the count of valid operands held in the pipeline stages.

Function
REQ-015 SHALL be SHW register stages: stage k (k = 0..SHW-1) shifts by 2^k when the carried shift[k] = 1, else passes through.
REQ-016 Each stage register SHALL carry data, the shift amount, direction, mode and a valid bit.
REQ-017 Rotate SHALL wrap the vacated bits from the opposite end.
REQ-018 Logical mode SHALL fill vacated bits with 0.
REQ-019 Arithmetic right SHALL fill vacated bits with the operand MSB (sign bit); arithmetic left SHALL equal logical left.
REQ-020 Global advance enable SHALL be en = !out_valid | out_ready.
REQ-021 in_ready SHALL equal en; a transfer occurs when in_valid & in_ready.
REQ-022 When en = 1, every stage SHALL load from its predecessor and stage 0 SHALL load the input with valid = in_valid.
REQ-023 When en = 0, all stage registers SHALL hold, including out_data and out_valid.
REQ-024 Latency SHALL be exactly SHW cycles from the accept edge to out_valid high, absent stalls.
REQ-025 Throughput SHALL be one operand per cycle while out_ready = 1; bubbles (in_valid = 0) SHALL propagate as invalid stages.
REQ-026 out_data/out_valid SHALL be the last stage's registers, with no combinational path from inputs to outputs except out_ready -> in_ready.
REQ-027 shift = 0 SHALL return in_data unchanged in every mode and direction.
REQ-028 inflight SHALL equal the population count of the stage valid bits, updated each edge; its maximum is SHW.
REQ-029 An accept and an output retire in the same cycle SHALL leave inflight unchanged.
REQ-030 Invalid stages SHALL still clock data when en = 1; their data is don't-care and unchecked.

Reset
REQ-031 rst_n = 0 SHALL immediately clear all stage valid bits and data to 0, giving out_valid = 0, out_data = 0 and inflight = 0.
REQ-032 During reset, in_ready SHALL be 1, since out_valid = 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset appears afterwards.
REQ-034 The first accept SHALL occur on the first rising edge after rst_n deasserts.

Verification (WIDTH = 8, SHW = 3)
REQ-035 Rotate left: 0x81, shift 1, direction 0, mode 00, out_ready = 1 -> out_data 0x03 with out_valid exactly 3 cycles after accept.
REQ-036 Arithmetic vs logical right: 0x90, shift 3, direction 1; mode 10 -> 0xF2, mode 01 -> 0x12; both issued back-to-back, results arrive on consecutive cycles.
REQ-037 Backpressure: 4 operands streamed, out_ready held 0 for 5 cycles after the first result -> in_ready = 0 and out_data stable throughout; after release, all 4 results arrive in order; inflight never exceeds 3.
REQ-038 Rotate right: 0x81, shift 4, direction 1, mode 00 -> 0x18; shift 0 in any mode -> 0x81.
REQ-039 Reset mid-stream: rst_n pulsed low with 2 operands in flight -> out_valid = 0 and inflight = 0 asynchronously; neither result ever appears.
REQ-040 Random stream, 1000 operands, random in_valid/out_ready -> output sequence matches the reference model in order, no drops, no duplicates.
